// File: rtl/four_digit_led_driver.sv
// Time-multiplexed scan driver for a four-digit common-anode seven-segment display.
// Holds a double-buffered message so that a new message only takes effect at a frame boundary.
module four_digit_led_driver #(
    parameter int DIGIT_CYCLES = 16000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] msg,
    input  logic        load,
    output logic [3:0]  an,
    output logic [3:0]  char
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);
    localparam logic [15:0]   ALL_SPACE = 16'hCCCC;

    logic [CW-1:0] cnt;
    logic [1:0]    slot;
    logic [15:0]   pending;
    logic [15:0]   display;

    logic slot_end;
    logic frame_end;

    assign slot_end  = (cnt == LAST_CNT);
    // Slot 0 is scanned last, so its final cycle closes the frame.
    assign frame_end = slot_end && (slot == 2'd0);

    // NOTE: every register here uses <= so all updates see the pre-edge values of cnt/slot/pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            slot    <= 2'd3;
            pending <= ALL_SPACE;
            display <= ALL_SPACE;
        end else begin
            if (slot_end) begin
                cnt  <= '0;
                slot <= slot - 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (load) begin
                pending <= msg;
            end

            // A load on the commit edge bypasses pending so it lands in the very next frame.
            if (frame_end) begin
                display <= load ? msg : pending;
            end
        end
    end

    always_comb begin
        case (slot)
            2'd3:    char = display[15:12];
            2'd2:    char = display[11:8];
            2'd1:    char = display[7:4];
            default: char = display[3:0];
        endcase
    end

    // NOTE: the default assignment before the conditional keeps this purely combinational (no latch).
    always_comb begin
        an = 4'b1111;
        if (cnt >= BLANK_CNT) begin
            an[slot] = 1'b0;
        end
    end

endmodule
